// File: rtl/seq_div_pkg.sv
// Shared constants and types for the sequential restoring divider.
package seq_div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold the value WIDTH itself, hence clog2(WIDTH+1).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Combinational (WIDTH+1)-bit trial subtractor built on an add/sub cell with M=1.
// Zero latency, no flow control; the borrow is the sign bit of the full-width difference.
module div_sub_stage
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH:0]   b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam logic M = 1'b1;

  logic [WIDTH:0] b_inv;
  logic [WIDTH:0] sum;

  // a + (b xor M) + M: two's-complement subtract when M=1.
  assign b_inv = b_i ^ {(WIDTH + 1){M}};
  assign sum   = a_i + b_inv + {{WIDTH{1'b0}}, M};

  assign diff_o   = sum[WIDTH-1:0];
  assign borrow_o = sum[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock behind a start/busy/done handshake.
// Latency WIDTH+1 cycles from start to done (1 for divide-by-zero); start during RUN is ignored.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_res_q;
  logic [WIDTH-1:0] r_res_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_borrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // A restored remainder is always below the divisor, so only the shifted
  // partial remainder needs the extra bit.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .a_i      (rem_shift),
    .b_i      ({1'b0, div_q}),
    .diff_o   (trial_diff),
    .borrow_o (trial_borrow)
  );

  assign rem_d = trial_borrow ? rem_shift[WIDTH-1:0] : trial_diff;
  assign quo_d = {quo_q[WIDTH-2:0], ~trial_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      q_res_q <= '0;
      r_res_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (B == '0) begin
              state_q <= DONE;
              q_res_q <= '1;
              r_res_q <= A;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              quo_q   <= A;
              div_q   <= B;
              rem_q   <= '0;
              cnt_q   <= CW'(WIDTH);
              dz_q    <= 1'b0;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            q_res_q <= quo_d;
            r_res_q <= rem_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q        = q_res_q;
  assign R        = r_res_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && done_q));

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops on done.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] A, B, Q, R;
  logic       busy, done, div_zero;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      chk("busy_done_excl", 32'(busy & done), 32'd0);
      if (done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done required=no_pending_op Q=%0d R=%0d", Q, R);
        end else begin
          e = sb.pop_front();
          chk("Q", 32'(Q), 32'(e.q));
          chk("R", 32'(R), 32'(e.r));
          chk("div_zero", 32'(div_zero), 32'(e.dz));
          if (!e.dz) begin
            chk("inv_a_eq_qb_plus_r", 32'(Q) * 32'(e.b) + 32'(R), 32'(e.a));
            chk("inv_r_lt_b", 32'(R < e.b), 32'd1);
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] q, input logic [3:0] r, input logic dz);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
    A = a;
    B = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done, counting busy cycles seen before it; leaves us in the done cycle.
  task automatic run_count(input string nm, input int exp_busy);
    int nb  = 0;
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) nb++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_within_40_cycles", nm);
    end
    chk({nm, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int d0;
    logic [3:0] a, b, q, r;
    logic dz;
    rst_n = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_Q", 32'(Q), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    issue(4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
    run_count("a13_b4", 4);
    @(negedge clk);
    chk("a13_b4_done_one_cycle", 32'(done), 32'd0);
    @(negedge clk);
    chk("a13_b4_hold_Q", 32'(Q), 32'd3);
    chk("a13_b4_hold_R", 32'(R), 32'd1);
    chk("a13_b4_idle_busy", 32'(busy), 32'd0);

    issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    run_count("a15_b1", 4);
    issue(4'd5, 4'd7, 4'd0, 4'd5, 1'b0);
    run_count("a5_b7", 4);
    issue(4'd0, 4'd3, 4'd0, 4'd0, 1'b0);
    run_count("a0_b3", 4);

    issue(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
    run_count("a9_b0", 0);
    issue(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);
    run_count("a8_b2", 4);

    // A second start during the second busy cycle must not disturb 14/3.
    issue(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
    @(posedge clk);
    #1;
    A = 4'd1;
    B = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    run_count("ignored_start", 2);

    // Abort 12/5 with reset in its second busy cycle.
    @(negedge clk);
    issue(4'd12, 4'd5, 4'd2, 4'd2, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_Q", 32'(Q), 32'd0);
    chk("abort_R", 32'(R), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_div_zero", 32'(div_zero), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    issue(4'd12, 4'd5, 4'd2, 4'd2, 1'b0);
    run_count("restart_a12_b5", 4);

    // Every pair, each start issued in the previous done cycle.
    for (int idx = 0; idx < 256; idx++) begin
      a = 4'(idx >> 4);
      b = 4'(idx);
      if (b == 4'd0) begin
        q = 4'd15;
        r = a;
        dz = 1'b1;
      end else begin
        q = a / b;
        r = a % b;
        dz = 1'b0;
      end
      issue(a, b, q, r, dz);
      run_count("sweep", (b == 4'd0) ? 0 : 4);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned restoring divider. Computes quotient and remainder of two WIDTH-bit operands by repeated shift-and-subtract, one quotient bit per clock.
- Performs the inverse of the arithmetic datapath's multiply direction, reusing the team's add/sub building block as its trial-subtract stage.
- Sits beside the combinational adder/subtractor in the arithmetic unit, behind a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled on rising clk edge
- A  input  WIDTH  dividend; sampled with accepted start
- B  input  WIDTH  divisor; sampled with accepted start
- Q  output  WIDTH  quotient; valid while done=1 and held until next accepted start
- R  output  WIDTH  remainder; same validity as Q
- busy  output  1  high while iterating
- done  output  1  one-cycle result-valid pulse
- div_zero  output  1  high with done when B was 0; held with Q/R

Behaviour:
- Reset: asynchronous on rst_n low, any state, including mid-operation. State=IDLE; Q=0, R=0, busy=0, done=0, div_zero=0; iteration counter=0; operand registers=0. No result is produced for an aborted operation.
- States: IDLE, RUN, DONE.
- Start acceptance: start is accepted in IDLE or DONE. start during RUN is ignored, with no effect on the operation in flight.
- Divide by zero: on accepted start with B==0:
  - Next state is DONE; no RUN cycles.
  - Q = all ones, R = A, div_zero = 1.
- Normal operation: on accepted start with B!=0:
  - Latch A into the quotient shift register and B into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits); counter = WIDTH.
  - div_zero = 0; state -> RUN.
- RUN, each cycle:
  - Shift {rem, quo} left by 1.
  - trial = shifted rem - {0,B}, computed at WIDTH+1 bits.
  - If trial has no borrow (MSB=0): rem = trial, quo[0] = 1. Otherwise rem is kept and quo[0] = 0.
  - Decrement counter. When the counter reaches 0 on this edge, state -> DONE and Q/R load from quo/rem[WIDTH-1:0].
- Latency: start accepted at edge k.
  - busy=1 after edges k .. k+WIDTH-1, i.e. exactly WIDTH cycles.
  - done=1 for exactly one cycle after edge k+WIDTH.
  - Divide-by-zero: done after edge k, busy never asserted.
- DONE: lasts one cycle.
  - With no start: -> IDLE, done drops, Q/R/div_zero hold.
  - With start: accepted as above; back-to-back operation is legal.
- Q/R outputs change only on entry to DONE or on reset. They never show intermediate values.
- Invariants (checked by assertion):
  - busy and done are never both 1.
  - When div_zero=0 at done: A == Q*B + R and R < B.

Decomposition:
- Shared package seq_div_pkg:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - default width constant DIV_WIDTH=4.
  - counter width helper, clog2(WIDTH+1).
- One sub-module: div_sub_stage. Combinational (WIDTH+1)-bit trial subtractor built on the team's add/sub cell with M=1 (subtract). It outputs the difference and the borrow flag.
- The FSM, counter and shift registers stay in seq_divider.

Test Plan:
- A=13, B=4, start 1 cycle -> busy 4 cycles, then done=1 one cycle with Q=3, R=1, div_zero=0; Q/R still 3/1 two cycles later.
- A=15/B=1 -> Q=15, R=0; A=5/B=7 -> Q=0, R=5; A=0/B=3 -> Q=0, R=0.
- A=9, B=0 -> done one cycle after start, busy never high, Q=15, R=9, div_zero=1. Then A=8/B=2 -> div_zero=0, Q=4, R=0.
- Start A=14/B=3, then assert start with A=1/B=1 on the second busy cycle -> ignored; result Q=4, R=2 at the normal done time.
- Start A=12/B=5; pull rst_n low on the 2nd busy cycle for 1 cycle -> all outputs 0 immediately, no done pulse. Restart A=12/B=5 -> Q=2, R=2.
- Exhaustive sweep of all 256 A,B pairs, with back-to-back starts issued in the done cycle -> each result matches a reference model. B=0 cases give Q=15, R=A, div_zero=1.
